alu_arbiter: RTL and testbench

- Shares one 32-bit ALU datapath instance between two requesters.
- Each requester submits an operation (operands, S/M/Cin mode) over a valid/ready handshake.
- Round-robin grant; the winner's operation is registered, driven to the ALU, and the result plus C/V/N/Z flags is returned on a single tagged response channel with backpressure.
- Sits between issuing units and the ALU datapath; the ALU itself is unchanged.

---
 rtl/alu_arbiter.sv | 103 ++++++++++
 tb/tb_alu_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two valid/ready requesters
module alu_arbiter #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [n-1:0] req0_opA,
  input  logic [n-1:0] req0_opB,
  input  logic [3:0]   req0_S,
  input  logic         req0_M,
  input  logic         req0_Cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [n-1:0] req1_opA,
  input  logic [n-1:0] req1_opB,
  input  logic [3:0]   req1_S,
  input  logic         req1_M,
  input  logic         req1_Cin,
  output logic [n-1:0] alu_opA,
  output logic [n-1:0] alu_opB,
  output logic [3:0]   alu_S,
  output logic         alu_M,
  output logic         alu_Cin,
  input  logic [n-1:0] alu_DO,
  input  logic         alu_C,
  input  logic         alu_V,
  input  logic         alu_N,
  input  logic         alu_Z,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [n-1:0] rsp_DO,
  output logic         rsp_C,
  output logic         rsp_V,
  output logic         rsp_N,
  output logic         rsp_Z,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t       state_q;
  logic         last_q, id_q, vld_q, gnt_d, hs;
  logic [n-1:0] opa_q, opb_q, do_q;
  logic [3:0]   s_q, flg_q;
  logic         m_q, cin_q;
  // on a tie the requester that did not win last time goes next
  always_comb begin
    gnt_d      = (req0_valid && req1_valid) ? !last_q : !req0_valid;
    req0_ready = (state_q == IDLE) && !rst && !gnt_d && req0_valid;
    req1_ready = (state_q == IDLE) && !rst && gnt_d && req1_valid;
    hs         = req0_ready || req1_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      vld_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      cin_q   <= 1'b0;
      do_q    <= '0;
      flg_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (hs) begin
          opa_q   <= gnt_d ? req1_opA : req0_opA;
          opb_q   <= gnt_d ? req1_opB : req0_opB;
          s_q     <= gnt_d ? req1_S : req0_S;
          m_q     <= gnt_d ? req1_M : req0_M;
          cin_q   <= gnt_d ? req1_Cin : req0_Cin;
          last_q  <= gnt_d;
          id_q    <= gnt_d;
          state_q <= EXEC;
        end
        EXEC: begin
          do_q    <= alu_DO;
          flg_q   <= {alu_C, alu_V, alu_N, alu_Z};
          vld_q   <= 1'b1;
          state_q <= RESP;
        end
        RESP: if (rsp_ready) begin
          vld_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign alu_opA   = opa_q;
  assign alu_opB   = opb_q;
  assign alu_S     = s_q;
  assign alu_M     = m_q;
  assign alu_Cin   = cin_q;
  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_DO    = do_q;
  assign {rsp_C, rsp_V, rsp_N, rsp_Z} = flg_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench with an adder ALU stub for alu_arbiter
module tb_alu_arbiter;
  typedef struct packed {
    logic        id;
    logic [31:0] d;
    logic [3:0]  f;
  } exp_t;
  logic        clk = 0, rst = 1;
  logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_opA = 0, req0_opB = 0, req1_opA = 0, req1_opB = 0;
  logic [3:0]  req0_S = 0, req1_S = 0;
  logic        req0_M = 0, req0_Cin = 0, req1_M = 0, req1_Cin = 0;
  logic [31:0] alu_opA, alu_opB, alu_DO, rsp_DO;
  logic [3:0]  alu_S;
  logic        alu_M, alu_Cin, alu_C, alu_V, alu_N, alu_Z;
  logic        rsp_valid, rsp_ready = 1, rsp_id, rsp_C, rsp_V, rsp_N, rsp_Z, busy;
  int          n_chk = 0, n_pass = 0, n_rsp = 0, cyc = 0, rv_cyc = 0, acc_cyc = 0, g0 = 0;
  logic        rv_prev = 0;
  exp_t        sb[$];
  exp_t        e;
  logic [37:0] snap;
  int          g_id[$];
  int          g_cyc[$];

  alu_arbiter #(.n(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opA(req0_opA), .req0_opB(req0_opB),
    .req0_S(req0_S), .req0_M(req0_M), .req0_Cin(req0_Cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opA(req1_opA), .req1_opB(req1_opB),
    .req1_S(req1_S), .req1_M(req1_M), .req1_Cin(req1_Cin),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_S(alu_S), .alu_M(alu_M), .alu_Cin(alu_Cin),
    .alu_DO(alu_DO), .alu_C(alu_C), .alu_V(alu_V), .alu_N(alu_N), .alu_Z(alu_Z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_DO(rsp_DO),
    .rsp_C(rsp_C), .rsp_V(rsp_V), .rsp_N(rsp_N), .rsp_Z(rsp_Z), .busy(busy)
  );

  // ALU stub: plain add with carry, signed overflow, sign and zero flags
  assign {alu_C, alu_DO} = {1'b0, alu_opA} + {1'b0, alu_opB} + {32'd0, alu_Cin};
  assign alu_V = (alu_opA[31] == alu_opB[31]) && (alu_DO[31] != alu_opA[31]);
  assign alu_N = alu_DO[31];
  assign alu_Z = alu_DO == 32'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic expect_rsp(input logic id, input logic [31:0] d, input logic [3:0] f);
    sb.push_back(exp_t'{id, d, f});
  endtask

  task automatic hold(input int r);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (r == 0 ? req0_ready : req1_ready) break;
    end
    if (k == 50) chk(r != 0 ? "tmo_gnt1" : "tmo_gnt0", 0, 1);
    @(posedge clk);
    #1;
    if (r == 0) req0_valid = 0;
    else req1_valid = 0;
  endtask

  task automatic wait_rsp(input int target);
    for (int k = 0; k < 60 && n_rsp < target; k++) @(posedge clk);
    chk("rsp_count", n_rsp, target);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("one_ready", req0_ready & req1_ready, 0);
      if (req0_ready) begin g_id.push_back(0); g_cyc.push_back(cyc); end
      if (req1_ready) begin g_id.push_back(1); g_cyc.push_back(cyc); end
      if (rsp_valid && !rv_prev) rv_cyc = cyc;
      if (rsp_valid && rsp_ready) begin
        acc_cyc = cyc;
        n_rsp++;
        if (sb.size() == 0) chk("sb_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_DO", rsp_DO, e.d);
          chk("rsp_CVNZ", {rsp_C, rsp_V, rsp_N, rsp_Z}, e.f);
        end
      end
    end
    rv_prev = rsp_valid;
  end

  initial begin
    // reset state, with req0 already requesting
    req0_opA = 32'h5; req0_opB = 32'h3; req0_Cin = 0; req0_S = 4'h9; req0_M = 1;
    req0_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_C, rsp_V, rsp_N, rsp_Z}, 0);
    chk("rst_alu", {alu_opA, alu_S, alu_M, alu_Cin}, 0);
    chk("rst_DO", rsp_DO, 0);
    // single request 5+3 and its two-cycle latency
    @(posedge clk); #1;
    rst = 0;
    expect_rsp(0, 32'h8, 4'b0000);
    hold(0);
    @(negedge clk);
    chk("exec_opA", alu_opA, 32'h5);
    chk("exec_opB", alu_opB, 32'h3);
    chk("exec_S_M", {alu_S, alu_M, alu_Cin}, {4'h9, 1'b1, 1'b0});
    chk("exec_busy", busy, 1);
    wait_rsp(1);
    chk("latency", rv_cyc - g_cyc[$], 2);
    // simultaneous requests from reset release: requester 0 first
    rst = 1;
    req0_opA = 32'h1; req0_opB = 32'h1; req0_Cin = 0; req0_M = 0; req0_S = 4'h0;
    req1_opA = 32'hFFFFFFFF; req1_opB = 32'h1; req1_Cin = 0;
    req0_valid = 1; req1_valid = 1;
    @(posedge clk); #1;
    rst = 0;
    g0 = g_id.size();
    expect_rsp(0, 32'h2, 4'b0000);
    expect_rsp(1, 32'h0, 4'b1001);
    fork
      hold(0);
      hold(1);
    join
    wait_rsp(3);
    chk("sim_order0", g_id[g0], 0);
    chk("sim_order1", g_id[g0+1], 1);
    // continuous contention for 12 cycles
    req0_opA = 32'h12345678; req0_opB = 32'h11111111; req0_Cin = 1;
    req1_opA = 32'h80000000; req1_opB = 32'h80000000; req1_Cin = 0;
    for (int i = 0; i < 2; i++) begin
      expect_rsp(0, 32'h2345678A, 4'b0000);
      expect_rsp(1, 32'h0, 4'b1101);
    end
    g0 = g_id.size();
    req0_valid = 1; req1_valid = 1;
    repeat (12) @(posedge clk);
    #1;
    req0_valid = 0; req1_valid = 0;
    chk("cont_ngrant", g_id.size() - g0, 4);
    for (int i = 0; i < 4; i++) chk("cont_alt", g_id[g0+i], i % 2);
    for (int i = 1; i < 4; i++) chk("cont_gap", g_cyc[g0+i] - g_cyc[g0+i-1], 3);
    wait_rsp(7);
    // backpressure with req1 waiting; req1 then overflows
    rsp_ready = 0;
    req0_opA = 32'hA; req0_opB = 32'h5; req0_Cin = 0;
    req1_opA = 32'h7FFFFFFF; req1_opB = 32'h1; req1_Cin = 0;
    expect_rsp(0, 32'hF, 4'b0000);
    expect_rsp(1, 32'h80000000, 4'b0110);
    req0_valid = 1; req1_valid = 1;
    hold(0);
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    chk("bp_valid", rsp_valid, 1);
    snap = {rsp_id, rsp_DO, rsp_C, rsp_V, rsp_N, rsp_Z, rsp_valid};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold", {rsp_id, rsp_DO, rsp_C, rsp_V, rsp_N, rsp_Z, rsp_valid}, snap);
      chk("bp_busy", busy, 1);
      chk("bp_ready", {req0_ready, req1_ready}, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    hold(1);
    chk("bp_grant_id", g_id[$], 1);
    chk("bp_grant_cyc", g_cyc[$] - acc_cyc, 1);
    wait_rsp(9);
    // reset during EXEC discards the operation and re-favours requester 0
    req1_opA = 32'h3; req1_opB = 32'h4; req1_Cin = 0;
    req1_valid = 1;
    hold(1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    req0_opA = 32'h100; req0_opB = 32'h200; req0_Cin = 1;
    req1_opA = 32'hFFFFFFFF; req1_opB = 32'hFFFFFFFF; req1_Cin = 1;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("rx_busy", busy, 0);
    chk("rx_rsp", {rsp_valid, rsp_id, rsp_C, rsp_V, rsp_N, rsp_Z}, 0);
    chk("rx_DO", rsp_DO, 0);
    chk("rx_alu", {alu_opA, alu_opB, alu_S, alu_M, alu_Cin}, 0);
    chk("rx_first", {req0_ready, req1_ready}, 2'b10);
    expect_rsp(0, 32'h301, 4'b0000);
    expect_rsp(1, 32'hFFFFFFFF, 4'b1010);
    fork
      hold(0);
      hold(1);
    join
    wait_rsp(11);
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
